// File: rtl/apb_mst_cmd_bridge_pkg.sv
// Shared definitions for the APB command bridge: FSM state encoding and width helpers.
package apb_mst_cmd_bridge_pkg;

    // Transfer sequencing states; 2-bit encoding shared with future APB requesters/completers.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Byte-strobe width for a given APB data width.
    function automatic int unsigned strb_width(input int unsigned data_size);
        return data_size / 8;
    endfunction

    // Wait-counter width; at least one bit so a disabled timeout still elaborates.
    function automatic int unsigned timer_width(input int unsigned timeout_cyc);
        return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_mst_cmd_bridge_wait_timer.sv
// ACCESS wait-state counter; flags the last allowed cycle before a hung-slave abort.
module apb_mst_cmd_bridge_wait_timer
    import apb_mst_cmd_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    if (TIMEOUT_CYC == 0) begin : g_off
        // Timeout disabled: never expire.
        assign expired_c = 1'b0;
    end else begin : g_on
        localparam int unsigned CNT_W = timer_width(TIMEOUT_CYC);

        logic [CNT_W-1:0] count;

        // Count wait cycles; cleared once per transfer on entry to ACCESS.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (enable) begin
                count <= count + CNT_W'(1);
            end
        end

        // High during the final permitted wait cycle.
        assign expired_c = (count == CNT_W'(TIMEOUT_CYC - 1));
    end

endmodule

// File: rtl/apb_mst_cmd_bridge.sv
// APB4 requester: single-beat local command port in, SETUP/ACCESS transfer out,
// PRDATA/PSLVERR (or timeout) returned on a registered response port.
module apb_mst_cmd_bridge
    import apb_mst_cmd_bridge_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned ADDR_SIZE   = 6,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_SIZE-1:0]   cmd_addr,
    input  logic [DATA_SIZE-1:0]   cmd_wdata,
    input  logic [DATA_SIZE/8-1:0] cmd_strb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_SIZE-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic [ADDR_SIZE-1:0]   PADDR,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [DATA_SIZE-1:0]   PWDATA,
    output logic [DATA_SIZE/8-1:0] PSTROBE,
    input  logic                   PREADY,
    input  logic [DATA_SIZE-1:0]   PRDATA,
    input  logic                   PSLVERR
);

    localparam int unsigned STRB_SIZE = strb_width(DATA_SIZE);

    state_e state;
    logic   timer_clear_c;
    logic   timer_en_c;
    logic   expired_c;

    // Timer restarts in SETUP and counts ACCESS cycles the slave holds off.
    assign timer_clear_c = (state == ST_SETUP);
    assign timer_en_c    = (state == ST_ACCESS) && !PREADY;

    apb_mst_cmd_bridge_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .clear     (timer_clear_c),
        .enable    (timer_en_c),
        .expired_c (expired_c)
    );

    // Transfer sequencer; every APB and response output is a flop.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTROBE     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PADDR     <= cmd_addr;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                        PSTROBE   <= cmd_write ? cmd_strb : STRB_SIZE'(0);
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? DATA_SIZE'(0) : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= ST_RESP;
                    end else if (expired_c) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mst_cmd_bridge.sv
// Directed bench for apb_mst_cmd_bridge with a wait-state/error-injecting APB slave model.
module tb_apb_mst_cmd_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [5:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTROBE;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    // slave model controls
    int          waits;
    logic        stuck;
    logic        err_inj;
    int          wcnt;
    logic [31:0] mem [16];

    int checks;
    int failures;

    // results of the last transfer
    int          first_psel;
    int          first_pen;
    int          setup_cnt;
    int          en_cnt;
    int          lat;
    logic        addr_ok;
    logic        done;
    logic [5:0]  cap_addr;
    logic [3:0]  cap_strb;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_to;

    apb_mst_cmd_bridge #(
        .DATA_SIZE   (32),
        .ADDR_SIZE   (6),
        .TIMEOUT_CYC (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSTROBE     (PSTROBE),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave: ready after 'waits' ACCESS cycles unless stuck; byte-strobed memory.
    assign PREADY  = PSEL && PENABLE && !stuck && (wcnt == waits);
    assign PRDATA  = mem[PADDR[5:2]];
    assign PSLVERR = err_inj;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (!PRESETn) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 | 32'(i);
        end else if (PSEL && PENABLE && PREADY && PWRITE) begin
            for (int b = 0; b < 4; b++)
                if (PSTROBE[b]) mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One command: accept at edge N, trace APB phases, then hold rsp_ready low 'hold' cycles.
    task automatic xfer(input logic w, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold);
        int cyc;
        @(negedge PCLK);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        cyc = 0; first_psel = 0; first_pen = 0; setup_cnt = 0; en_cnt = 0; lat = 0;
        addr_ok = 1'b1; done = 1'b0; cap_addr = '0; cap_strb = '0;
        while (!done && cyc < 60) begin
            @(negedge PCLK);
            cyc++;
            if (PSEL && first_psel == 0) begin
                first_psel = cyc; cap_addr = PADDR; cap_strb = PSTROBE;
            end
            if (PSEL && PADDR !== cap_addr) addr_ok = 1'b0;
            if (PENABLE && first_pen == 0) first_pen = cyc;
            if (PSEL && !PENABLE) setup_cnt++;
            if (PENABLE) en_cnt++;
            if (rsp_valid) begin lat = cyc; done = 1'b1; end
        end
        chk("rsp_seen", 32'(done), 32'd1);
        r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h3C;
            end
            @(negedge PCLK);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, r_rdata);
            chk("hold_err_to", 32'({rsp_err, rsp_timeout}), 32'({r_err, r_to}));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_psel", 32'(PSEL), 32'd0);
            chk("hold_paddr", 32'(PADDR), 32'(a));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge PCLK);
        #1 rsp_ready = 1'b0;
        @(negedge PCLK);
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_paddr_hold", 32'(PADDR), 32'(a));
    endtask

    initial begin
        checks = 0; failures = 0;
        waits = 0; stuck = 1'b0; err_inj = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        rsp_ready = 1'b0;
        PRESETn = 1'b0;
        #13;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_psel_pen", 32'({PSEL, PENABLE}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // zero-wait full-strobe write
        xfer(1'b1, 6'h04, 32'hA5A5_1234, 4'hF, 0);
        chk("wr_first_psel", 32'(first_psel), 32'd1);
        chk("wr_first_pen", 32'(first_pen), 32'd2);
        chk("wr_setup_cycles", 32'(setup_cnt), 32'd1);
        chk("wr_access_cycles", 32'(en_cnt), 32'd1);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_pstrobe", 32'(cap_strb), 32'hF);
        chk("wr_err", 32'(r_err), 32'd0);
        chk("wr_rdata_zero", r_rdata, 32'd0);

        // readback
        xfer(1'b0, 6'h04, 32'hDEAD_BEEF, 4'hF, 0);
        chk("rd_rdata", r_rdata, 32'hA5A5_1234);
        chk("rd_pstrobe_zero", 32'(cap_strb), 32'd0);
        chk("rd_latency", 32'(lat), 32'd3);

        // single-byte write then readback
        xfer(1'b1, 6'h04, 32'h0000_00FF, 4'h1, 0);
        chk("wrb_pstrobe", 32'(cap_strb), 32'h1);
        xfer(1'b0, 6'h04, 32'h0, 4'h0, 0);
        chk("rdb_rdata", r_rdata, 32'hA5A5_12FF);

        // read with 3 wait states
        waits = 3;
        xfer(1'b0, 6'h04, 32'h0, 4'h0, 0);
        chk("ws_access_cycles", 32'(en_cnt), 32'd4);
        chk("ws_latency", 32'(lat), 32'd6);
        chk("ws_addr_stable", 32'(addr_ok), 32'd1);
        chk("ws_rdata", r_rdata, 32'hA5A5_12FF);
        waits = 0;

        // slave error
        err_inj = 1'b1;
        xfer(1'b0, 6'h30, 32'h0, 4'h0, 0);
        chk("err_err", 32'(r_err), 32'd1);
        chk("err_timeout", 32'(r_to), 32'd0);
        chk("err_rdata", r_rdata, 32'h1000_000C);
        err_inj = 1'b0;

        // hung slave: timeout abort, response held 5 cycles, stray command ignored
        stuck = 1'b1;
        xfer(1'b0, 6'h08, 32'h0, 4'h0, 5);
        chk("to_access_cycles", 32'(en_cnt), 32'd16);
        chk("to_latency", 32'(lat), 32'd18);
        chk("to_err", 32'(r_err), 32'd1);
        chk("to_timeout", 32'(r_to), 32'd1);
        chk("to_rdata", r_rdata, 32'd0);

        // reset during ACCESS
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h0C;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("mid_in_access", 32'({PSEL, PENABLE}), 32'h3);
        #2 PRESETn = 1'b0;
        #1;
        chk("mid_psel_pen", 32'({PSEL, PENABLE}), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge PCLK);
        stuck = 1'b0;
        PRESETn = 1'b1;
        xfer(1'b0, 6'h04, 32'h0, 4'h0, 0);
        chk("after_rst_rdata", r_rdata, 32'h1000_0001);
        chk("after_rst_err", 32'({r_err, r_to}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
